// File: rtl/demod_16qam_pkg.sv
// rtl/demod_16qam_pkg.sv - shared widths, symbol-code type and carrier wave helpers
package demod_16qam_pkg;

  localparam int SAMPLE_W   = 9;
  localparam int CARR_W     = 8;
  localparam int PROD_W     = 17;
  localparam int FRAME_SYMS = 32;
  localparam int CODE_W     = 4;
  localparam int FRAME_W    = FRAME_SYMS * CODE_W;

  typedef logic [CODE_W-1:0] sym_code_t;

  // First quadrant of round(127*sin(2*pi*r/64)), r = 0..16.
  function automatic logic signed [CARR_W-1:0] quarter_sin(input logic [4:0] r);
    logic signed [CARR_W-1:0] v;
    case (r)
      5'd0:    v = 8'sd0;
      5'd1:    v = 8'sd12;
      5'd2:    v = 8'sd25;
      5'd3:    v = 8'sd37;
      5'd4:    v = 8'sd49;
      5'd5:    v = 8'sd60;
      5'd6:    v = 8'sd71;
      5'd7:    v = 8'sd81;
      5'd8:    v = 8'sd90;
      5'd9:    v = 8'sd98;
      5'd10:   v = 8'sd106;
      5'd11:   v = 8'sd112;
      5'd12:   v = 8'sd117;
      5'd13:   v = 8'sd122;
      5'd14:   v = 8'sd125;
      5'd15:   v = 8'sd126;
      5'd16:   v = 8'sd127;
      default: v = 8'sd0;
    endcase
    return v;
  endfunction

  // Full 64-point sine built from quadrant symmetry.
  function automatic logic signed [CARR_W-1:0] wave_sin(input logic [5:0] m);
    logic [4:0] r;
    logic signed [CARR_W-1:0] q;
    r = m[4] ? (5'd16 - {1'b0, m[3:0]}) : {1'b0, m[3:0]};
    q = quarter_sin(r);
    return m[5] ? -q : q;
  endfunction

endpackage

// File: rtl/demod_carrier_lut.sv
// rtl/demod_carrier_lut.sv - combinational sin/cos carrier lookup indexed by phase
module demod_carrier_lut
  import demod_16qam_pkg::*;
#(
  parameter int CARR_LEN = 16
) (
  input  logic [$clog2(CARR_LEN)-1:0] phase,
  output logic signed [CARR_W-1:0]    sin_val,
  output logic signed [CARR_W-1:0]    cos_val
);

  localparam int PW = $clog2(CARR_LEN);
  localparam int SH = 6 - PW;

  logic [5:0] m_sin;
  logic [5:0] m_cos;

  // Scale the phase onto the 64-point wave; cosine leads sine by a quarter turn.
  assign m_sin   = 6'(phase) << SH;
  assign m_cos   = m_sin + 6'd16;
  assign sin_val = wave_sin(m_sin);
  assign cos_val = wave_sin(m_cos);

endmodule

// File: rtl/demod_16qam.sv
// rtl/demod_16qam.sv - 16QAM correlating demodulator with frame packer; DEMOD_16QAM_SERIAL_EN adds a bit serializer
module demod_16qam
  import demod_16qam_pkg::*;
#(
  parameter int CARR_LEN = 16,
  parameter int SYM_LEN  = 64,
  parameter int THRESH   = 24384
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic signed [SAMPLE_W-1:0] in_sample,
  input  logic                       sym_sync,
  output sym_code_t                  sym_code,
  output logic                       sym_valid,
  output logic [FRAME_W-1:0]         d_out,
  output logic                       frame_valid
`ifdef DEMOD_16QAM_SERIAL_EN
  ,
  output logic                       serial_data,
  output logic                       bit_valid
`endif
);

  localparam int PW = $clog2(CARR_LEN);
  localparam int CW = $clog2(SYM_LEN);
  localparam int AW = PROD_W + CW;
  localparam int FW = $clog2(FRAME_SYMS);
  localparam logic signed [AW-1:0] TH = AW'(THRESH);

  logic [PW-1:0]              phase, phase_eff;
  logic [CW-1:0]              cnt, cnt_eff;
  logic signed [AW-1:0]       acc_i, acc_q, base_i, base_q, sum_i, sum_q;
  logic signed [CARR_W-1:0]   sin_val, cos_val;
  logic signed [PROD_W-1:0]   prod_i, prod_q;
  logic [1:0]                 dec_i, dec_q;
  logic                       sym_end;
  sym_code_t                  code_next;
  logic [FRAME_W-1:0]         frame_sr, frame_next;
  logic [FW-1:0]              frame_idx;

  function automatic logic [1:0] slice(input logic signed [AW-1:0] a);
    if (a < -TH)       return 2'b00;
    else if (a < 0)    return 2'b01;
    else if (a < TH)   return 2'b10;
    else               return 2'b11;
  endfunction

  // A sync restarts alignment in the same cycle, so its sample is sample 0 at phase 0.
  assign phase_eff = sym_sync ? '0 : phase;
  assign cnt_eff   = sym_sync ? '0 : cnt;
  assign base_i    = sym_sync ? '0 : acc_i;
  assign base_q    = sym_sync ? '0 : acc_q;

  demod_carrier_lut #(.CARR_LEN(CARR_LEN)) u_lut (
    .phase   (phase_eff),
    .sin_val (sin_val),
    .cos_val (cos_val)
  );

  assign prod_i     = PROD_W'(in_sample) * PROD_W'(cos_val);
  assign prod_q     = PROD_W'(in_sample) * PROD_W'(sin_val);
  assign sum_i      = base_i + AW'(prod_i);
  assign sum_q      = base_q + AW'(prod_q);
  assign sym_end    = in_valid && (cnt_eff == CW'(SYM_LEN - 1));
  assign dec_i      = slice(sum_i);
  assign dec_q      = slice(sum_q);
  assign code_next  = {dec_i[1], dec_q[1], dec_i[0], dec_q[0]};
  assign frame_next = {frame_sr[FRAME_W-CODE_W-1:0], code_next};

  always_ff @(posedge clk) begin
    if (reset) begin
      phase       <= '0;
      cnt         <= '0;
      acc_i       <= '0;
      acc_q       <= '0;
      sym_code    <= '0;
      sym_valid   <= 1'b0;
      frame_sr    <= '0;
      frame_idx   <= '0;
      d_out       <= '0;
      frame_valid <= 1'b0;
    end else begin
      sym_valid   <= 1'b0;
      frame_valid <= 1'b0;
      if (in_valid) begin
        phase <= phase_eff + PW'(1);
        if (sym_end) begin
          acc_i     <= '0;
          acc_q     <= '0;
          cnt       <= '0;
          sym_code  <= code_next;
          sym_valid <= 1'b1;
          frame_sr  <= frame_next;
          frame_idx <= frame_idx + FW'(1);
          if (frame_idx == FW'(FRAME_SYMS - 1)) begin
            d_out       <= frame_next;
            frame_valid <= 1'b1;
          end
        end else begin
          acc_i <= sum_i;
          acc_q <= sum_q;
          cnt   <= cnt_eff + CW'(1);
        end
      end else begin
        phase <= phase_eff;
        acc_i <= base_i;
        acc_q <= base_q;
        cnt   <= cnt_eff;
      end
    end
  end

`ifdef DEMOD_16QAM_SERIAL_EN
  logic [2:0] ser_sr;
  logic [1:0] ser_left;

  // A new symbol always reloads, even if a previous one were still shifting.
  always_ff @(posedge clk) begin
    if (reset) begin
      ser_sr      <= '0;
      ser_left    <= '0;
      serial_data <= 1'b0;
      bit_valid   <= 1'b0;
    end else if (sym_valid) begin
      serial_data <= sym_code[3];
      ser_sr      <= sym_code[2:0];
      ser_left    <= 2'd3;
      bit_valid   <= 1'b1;
    end else if (ser_left != 2'd0) begin
      serial_data <= ser_sr[2];
      ser_sr      <= {ser_sr[1:0], 1'b0};
      ser_left    <= ser_left - 2'd1;
      bit_valid   <= 1'b1;
    end else begin
      serial_data <= 1'b0;
      bit_valid   <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_demod_16qam.sv
// tb/tb_demod_16qam.sv - directed self-checking bench for demod_16qam
module tb_demod_16qam;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic signed [8:0] in_sample;
  logic              sym_sync;
  logic [3:0]        sym_code;
  logic              sym_valid;
  logic [127:0]      d_out;
  logic              frame_valid;
`ifdef DEMOD_16QAM_SERIAL_EN
  logic              serial_data;
  logic              bit_valid;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int pulses   = 0;
  int cos_t [16] = '{127, 117, 90, 49, 0, -49, -90, -117, -127, -117, -90, -49, 0, 49, 90, 117};

  always #5 clk = ~clk;

  demod_16qam dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_sample   (in_sample),
    .sym_sync    (sym_sync),
    .sym_code    (sym_code),
    .sym_valid   (sym_valid),
    .d_out       (d_out),
    .frame_valid (frame_valid)
`ifdef DEMOD_16QAM_SERIAL_EN
    ,
    .serial_data (serial_data),
    .bit_valid   (bit_valid)
`endif
  );

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    pulses += int'(sym_valid);
  endtask

  // kind 0: 3*cos-3*sin clamped; kind 1: xi at phase 0, yq at phase 4 (acc = 508*level)
  function automatic int sample_for(input int kind, input int n, input int xi, input int yq);
    int k, v;
    k = n % 16;
    if (kind == 0) begin
      v = 3 * cos_t[k] - 3 * cos_t[(k + 12) % 16];
      if (v > 255) v = 255;
      if (v < -256) v = -256;
    end else begin
      v = (k == 0) ? xi : ((k == 4) ? yq : 0);
    end
    return v;
  endfunction

  function automatic int lvl(input logic [1:0] b);
    case (b)
      2'b00:   return -100;
      2'b01:   return -10;
      2'b10:   return 10;
      default: return 100;
    endcase
  endfunction

  task automatic run_symbol(input int kind, input int xi, input int yq, input bit gap, input bit sync_first);
    for (int n = 0; n < 64; n++) begin
      in_sample = 9'(sample_for(kind, n, xi, yq));
      in_valid  = 1'b1;
      sym_sync  = sync_first && (n == 0);
      tick();
      if (gap && n < 63) begin
        in_valid  = 1'b0;
        sym_sync  = 1'b0;
        in_sample = 9'sd100;
        tick();
      end
    end
    in_valid = 1'b0;
    sym_sync = 1'b0;
  endtask

  task automatic run_code(input logic [3:0] c);
    run_symbol(1, lvl({c[3], c[1]}), lvl({c[2], c[0]}), 1'b0, 1'b0);
  endtask

  initial begin
    logic [3:0] exp_c;
    reset = 1'b1; in_valid = 1'b0; sym_sync = 1'b0; in_sample = '0;
    tick(); tick();
    check_val("reset_sym_code", 128'(sym_code), 128'h0);
    check_val("reset_sym_valid", 128'(sym_valid), 128'h0);
    check_val("reset_d_out", d_out, 128'h0);
    check_val("reset_frame_valid", 128'(frame_valid), 128'h0);
`ifdef DEMOD_16QAM_SERIAL_EN
    check_val("reset_bit_valid", 128'(bit_valid), 128'h0);
`endif
    reset = 1'b0;

    pulses = 0;
    run_symbol(0, 0, 0, 1'b0, 1'b0);
    check_val("wave_sym_valid", 128'(sym_valid), 128'h1);
    check_val("wave_sym_code", 128'(sym_code), 128'ha);
    check_val("wave_pulses", 128'(pulses), 128'd1);
    tick();
    check_val("wave_strobe_width", 128'(sym_valid), 128'h0);

    run_symbol(1, 48, -48, 1'b0, 1'b0);
    check_val("thresh_exact", 128'(sym_code), 128'hb);
    run_symbol(1, 47, -49, 1'b0, 1'b0);
    check_val("thresh_near", 128'(sym_code), 128'h8);
    run_symbol(1, 0, -1, 1'b0, 1'b0);
    check_val("zero_edge", 128'(sym_code), 128'h9);

    reset = 1'b1; tick(); reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      run_code(4'(i % 16));
      if (i == 30) check_val("frame_valid_early", 128'(frame_valid), 128'h0);
    end
    check_val("frame_valid_32", 128'(frame_valid), 128'h1);
    check_val("frame_sym_valid_32", 128'(sym_valid), 128'h1);
    check_val("frame_d_out", d_out, 128'h0123456789ABCDEF0123456789ABCDEF);
    tick();
    check_val("frame_valid_width", 128'(frame_valid), 128'h0);

    pulses = 0;
    for (int n = 0; n < 20; n++) begin
      in_sample = ((n % 16) == 0 || (n % 16) == 4) ? 9'sd127 : 9'sd0;
      in_valid  = 1'b1;
      tick();
    end
    run_symbol(1, -100, -100, 1'b0, 1'b1);
    check_val("sync_pulses", 128'(pulses), 128'd1);
    check_val("sync_sym_valid", 128'(sym_valid), 128'h1);
    check_val("sync_sym_code", 128'(sym_code), 128'h0);

    pulses = 0;
    run_symbol(0, 0, 0, 1'b1, 1'b0);
    check_val("gap_sym_valid", 128'(sym_valid), 128'h1);
    check_val("gap_sym_code", 128'(sym_code), 128'ha);
    check_val("gap_pulses", 128'(pulses), 128'd1);

    pulses = 0;
    for (int n = 0; n < 40; n++) begin
      in_sample = 9'(sample_for(1, n, 100, 100));
      in_valid  = 1'b1;
      tick();
    end
    reset = 1'b1;
    tick();
    check_val("midrst_sym_code", 128'(sym_code), 128'h0);
    check_val("midrst_sym_valid", 128'(sym_valid), 128'h0);
    check_val("midrst_d_out", d_out, 128'h0);
    check_val("midrst_frame_valid", 128'(frame_valid), 128'h0);
    check_val("midrst_pulses", 128'(pulses), 128'd0);
    reset = 1'b0; in_valid = 1'b0;
    exp_c = 4'b1101;
    run_code(exp_c);
    check_val("post_rst_sym_valid", 128'(sym_valid), 128'h1);
    check_val("post_rst_sym_code", 128'(sym_code), 128'(exp_c));
`ifdef DEMOD_16QAM_SERIAL_EN
    check_val("ser_idle", 128'(bit_valid), 128'h0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check_val("ser_bit_valid", 128'(bit_valid), 128'h1);
      check_val("ser_data", 128'(serial_data), 128'(exp_c[3 - k]));
    end
    tick();
    check_val("ser_done", 128'(bit_valid), 128'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
